// File: rtl/rpe_array_scheduler.sv
// rtl/rpe_array_scheduler.sv - weight-stationary tile pass sequencer for a SIZE x SIZE RPE array
//
// Purpose: runs one tile pass. It loads weights bottom row first (LOAD_W), streams
// activation vectors (STREAM), waits for the skewed wavefront to leave the array
// (DRAIN), then pulses done (FIN).
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_start               pass request, sampled only in IDLE
//   i_skip_wload          reuse resident weights (skip LOAD_W), sampled with start
//   i_num_vectors         activation vectors this pass, clamped to MAX_VEC
//   o_busy, o_done        pass in progress / one-cycle end-of-pass pulse
//   o_w_rd_en/addr        weight-buffer read (1-cycle latency buffer)
//   o_wgt_valid           weight shift valid for the top-row cells
//   o_act_rd_en/addr      activation-buffer read (1-cycle latency buffer)
//   o_act_row_valid       per-row skewed activation valid
//   o_out_col_valid       per-column bottom partial-sum capture valid
module rpe_array_scheduler #(
    parameter int SIZE    = 8,
    parameter int MAX_VEC = 256,
    parameter int VEC_W   = $clog2(MAX_VEC + 1),
    parameter int ADDR_W  = $clog2(MAX_VEC)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_skip_wload,
    input  logic [VEC_W-1:0]         i_num_vectors,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_w_rd_en,
    output logic [$clog2(SIZE)-1:0]  o_w_rd_addr,
    output logic                     o_wgt_valid,
    output logic                     o_act_rd_en,
    output logic [ADDR_W-1:0]        o_act_rd_addr,
    output logic [SIZE-1:0]          o_act_row_valid,
    output logic [SIZE-1:0]          o_out_col_valid
);

    localparam int WA_W = $clog2(SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t              r_state;
    logic [VEC_W-1:0]    r_last;    // index of the final vector of this pass
    logic [2*SIZE-1:0]   r_dl;      // r_dl[k] = act_rd_en delayed k+1 cycles
    logic [VEC_W-1:0]    w_clamped;

    assign w_clamped = (i_num_vectors > VEC_W'(MAX_VEC)) ? VEC_W'(MAX_VEC) : i_num_vectors;

    // Low half of the delay line is the row skew, high half the column capture.
    assign o_act_row_valid = r_dl[SIZE-1:0];
    assign o_out_col_valid = r_dl[2*SIZE-1:SIZE];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_last        <= '0;
            r_dl          <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_w_rd_en     <= 1'b0;
            o_w_rd_addr   <= '0;
            o_wgt_valid   <= 1'b0;
            o_act_rd_en   <= 1'b0;
            o_act_rd_addr <= '0;
        end else begin
            r_dl        <= {r_dl[2*SIZE-2:0], o_act_rd_en};
            // Weight data arrives one cycle after the read strobe.
            o_wgt_valid <= o_w_rd_en;
            o_done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    o_busy <= 1'b0;
                    if (i_start) begin
                        o_busy <= 1'b1;
                        r_last <= w_clamped - 1'b1;
                        if (w_clamped == '0) begin
                            r_state <= S_FIN;
                        end else if (i_skip_wload) begin
                            o_act_rd_en   <= 1'b1;
                            o_act_rd_addr <= '0;
                            r_state       <= S_STREAM;
                        end else begin
                            o_w_rd_en   <= 1'b1;
                            o_w_rd_addr <= WA_W'(SIZE - 1);
                            r_state     <= S_LOAD_W;
                        end
                    end
                end

                S_LOAD_W: begin
                    if (o_w_rd_addr == '0) begin
                        // First activation read lines up with the last wgt_valid cycle.
                        o_w_rd_en     <= 1'b0;
                        o_act_rd_en   <= 1'b1;
                        o_act_rd_addr <= '0;
                        r_state       <= S_STREAM;
                    end else begin
                        o_w_rd_addr <= o_w_rd_addr - 1'b1;
                    end
                end

                S_STREAM: begin
                    if (VEC_W'(o_act_rd_addr) == r_last) begin
                        o_act_rd_en <= 1'b0;
                        r_state     <= S_DRAIN;
                    end else begin
                        o_act_rd_addr <= o_act_rd_addr + 1'b1;
                    end
                end

                S_DRAIN: begin
                    // Leave one cycle early: when only the top tap still holds the
                    // last token, it reaches out_col_valid[SIZE-1] during FIN and
                    // the line is empty in the done cycle.
                    if (!o_act_rd_en && (r_dl[2*SIZE-3:0] == '0)) begin
                        r_state <= S_FIN;
                    end
                end

                S_FIN: begin
                    o_done  <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpe_array_scheduler.sv
// tb/tb_rpe_array_scheduler.sv - self-checking bench for rpe_array_scheduler
module tb_rpe_array_scheduler;

    localparam int SIZE    = 8;
    localparam int MAX_VEC = 256;
    localparam int VEC_W   = $clog2(MAX_VEC + 1);
    localparam int ADDR_W  = $clog2(MAX_VEC);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    skip_wload = 1'b0;
    logic [VEC_W-1:0]        num_vectors = '0;
    logic                    busy, done, w_rd_en, wgt_valid, act_rd_en;
    logic [$clog2(SIZE)-1:0] w_rd_addr;
    logic [ADDR_W-1:0]       act_rd_addr;
    logic [SIZE-1:0]         act_row_valid, out_col_valid;

    rpe_array_scheduler #(.SIZE(SIZE), .MAX_VEC(MAX_VEC), .VEC_W(VEC_W), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_skip_wload(skip_wload),
        .i_num_vectors(num_vectors), .o_busy(busy), .o_done(done),
        .o_w_rd_en(w_rd_en), .o_w_rd_addr(w_rd_addr), .o_wgt_valid(wgt_valid),
        .o_act_rd_en(act_rd_en), .o_act_rd_addr(act_rd_addr),
        .o_act_row_valid(act_row_valid), .o_out_col_valid(out_col_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit known = 0;

    // Reference model: one pass record (start cycle, clamped N, skip flag).
    bit have_pass = 0;
    int ps = 0;
    int pn = 0;
    bit pskip = 0;

    // Observations for literal pins.
    int obs_done = -1;
    int obs_done_cnt = 0;
    int obs_first_act = -1;
    int obs_col7_last = -1;
    int obs_act_cnt = 0;
    int obs_w_cnt = 0;
    int obs_last_addr = -1;

    function automatic int load_len();
        return pskip ? 0 : SIZE;
    endfunction

    function automatic int done_rel();
        return (pn == 0) ? 2 : load_len() + 2 * SIZE + pn + 1;
    endfunction

    function automatic bit act_at(int r);
        int l = load_len();
        return (pn > 0) && (r >= l + 1) && (r <= l + pn);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic compare();
        int r;
        int e_busy, e_done, e_w, e_wa, e_wv, e_a, e_aa, e_row, e_col;
        e_busy = 0; e_done = 0; e_w = 0; e_wa = 0; e_wv = 0;
        e_a = 0; e_aa = 0; e_row = 0; e_col = 0;
        if (have_pass) begin
            r = cyc - ps;
            e_busy = (r >= 1 && r <= done_rel()) ? 1 : 0;
            e_done = (r == done_rel()) ? 1 : 0;
            if (!pskip && pn > 0) begin
                e_w  = (r >= 1 && r <= SIZE) ? 1 : 0;
                e_wa = SIZE - r;
                e_wv = (r >= 2 && r <= SIZE + 1) ? 1 : 0;
            end
            e_a  = act_at(r) ? 1 : 0;
            e_aa = r - load_len() - 1;
            for (int i = 0; i < SIZE; i++) begin
                if (act_at(r - 1 - i))        e_row |= (1 << i);
                if (act_at(r - SIZE - 1 - i)) e_col |= (1 << i);
            end
        end
        chk("busy", int'(busy), e_busy);
        chk("done", int'(done), e_done);
        chk("w_rd_en", int'(w_rd_en), e_w);
        if (e_w != 0) chk("w_rd_addr", int'(w_rd_addr), e_wa);
        chk("wgt_valid", int'(wgt_valid), e_wv);
        chk("act_rd_en", int'(act_rd_en), e_a);
        if (e_a != 0) chk("act_rd_addr", int'(act_rd_addr), e_aa);
        chk("act_row_valid", int'(act_row_valid), e_row);
        chk("out_col_valid", int'(out_col_valid), e_col);
    endtask

    task automatic clear_obs();
        obs_done = -1; obs_done_cnt = 0; obs_first_act = -1; obs_col7_last = -1;
        obs_act_cnt = 0; obs_w_cnt = 0; obs_last_addr = -1;
    endtask

    // One cycle: check outputs of this cycle, then drive inputs sampled at its end.
    task automatic step(input logic st, input logic sk, input int n, input logic rn);
        @(negedge clk);
        if (known) begin
            compare();
            if (done === 1'b1) begin
                if (obs_done < 0) obs_done = cyc;
                obs_done_cnt++;
            end
            if (act_rd_en === 1'b1) begin
                if (obs_first_act < 0) obs_first_act = cyc;
                obs_act_cnt++;
                obs_last_addr = int'(act_rd_addr);
            end
            if (w_rd_en === 1'b1) obs_w_cnt++;
            if (out_col_valid[SIZE-1] === 1'b1) obs_col7_last = cyc;
        end
        start = st;
        skip_wload = sk;
        num_vectors = VEC_W'(n);
        rst_n = rn;
        if (!rn) begin
            have_pass = 0;
            known = 1;
        end else if (st && (!have_pass || cyc >= ps + done_rel())) begin
            have_pass = 1;
            ps = cyc;
            pn = (n > MAX_VEC) ? MAX_VEC : n;
            pskip = sk;
        end
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (obs_done < 0 && k < budget) begin
            step(1'b0, 1'b0, 0, 1'b1);
            k++;
        end
        chk("done_seen", (obs_done >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        int s;
        repeat (3) step(1'b0, 1'b0, 0, 1'b0);
        idle(2);

        // N=4 with weight load.
        clear_obs(); s = cyc;
        step(1'b1, 1'b0, 4, 1'b1);
        wait_done(100);
        chk("n4_done_rel", obs_done - s, 29);
        chk("n4_first_act_rel", obs_first_act - s, 9);
        chk("n4_col7_last_rel", obs_col7_last - s, 28);
        chk("n4_act_cnt", obs_act_cnt, 4);
        chk("n4_w_cnt", obs_w_cnt, 8);
        chk("n4_last_addr", obs_last_addr, 3);

        // skip_wload, N=1.
        clear_obs(); s = cyc;
        step(1'b1, 1'b1, 1, 1'b1);
        wait_done(100);
        chk("skip_done_rel", obs_done - s, 18);
        chk("skip_first_act_rel", obs_first_act - s, 1);
        chk("skip_col7_rel", obs_col7_last - s, 17);
        chk("skip_w_cnt", obs_w_cnt, 0);

        // N=0.
        clear_obs(); s = cyc;
        step(1'b1, 1'b0, 0, 1'b1);
        wait_done(20);
        chk("n0_done_rel", obs_done - s, 2);
        chk("n0_reads", obs_act_cnt + obs_w_cnt, 0);

        // Clamp N=300 to 256.
        clear_obs(); s = cyc;
        step(1'b1, 1'b0, 300, 1'b1);
        wait_done(700);
        chk("clamp_act_cnt", obs_act_cnt, 256);
        chk("clamp_last_addr", obs_last_addr, 255);
        chk("clamp_done_rel", obs_done - s, 281);

        // start re-pulsed during STREAM is ignored.
        clear_obs(); s = cyc;
        step(1'b1, 1'b0, 4, 1'b1);
        idle(9);
        step(1'b1, 1'b1, 9, 1'b1);
        wait_done(100);
        chk("repulse_done_rel", obs_done - s, 29);
        chk("repulse_act_cnt", obs_act_cnt, 4);
        chk("repulse_done_cnt", obs_done_cnt, 1);

        // start in the cycle after done is accepted.
        clear_obs(); s = cyc;
        step(1'b1, 1'b1, 2, 1'b1);
        wait_done(100);
        chk("after_done_rel", obs_done - s, 19);

        // Reset at cycle 12 of an N=4 pass.
        clear_obs(); s = cyc;
        step(1'b1, 1'b0, 4, 1'b1);
        idle(11);
        step(1'b0, 1'b0, 0, 1'b0);
        idle(40);
        chk("abort_done_cnt", obs_done_cnt, 0);
        clear_obs(); s = cyc;
        step(1'b1, 1'b0, 4, 1'b1);
        wait_done(100);
        chk("fresh_done_rel", obs_done - s, 29);
        chk("fresh_act_cnt", obs_act_cnt, 4);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic st, sk, rn;
            int n;
            st = ($urandom % 4) == 0;
            sk = $urandom % 2;
            n  = (($urandom % 10) == 0) ? $urandom_range(257, 300) : $urandom_range(0, 12);
            rn = ($urandom % 300) != 0;
            step(st, sk, n, rn);
        end
        idle(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
